div_sequencer: RTL and testbench
================================

# div_sequencer

Multi-cycle divide controller in the EXE stage. It accepts one div/divu/mod/modu request at a time from the pipeline and launches it on one of two external AXI-Stream divider IP instances, one signed and one unsigned. It waits for the quotient/remainder, then presents the selected 32-bit result on a valid/ready response port. It owns pipeline flush handling: an operation already handed to an IP cannot be aborted, so it is drained and discarded.

## Interface
- No parameters; data width fixed at 32.
- clk  in  1  single clock, all state on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept; equals (state == IDLE).
- req_op  in  4  one-hot {modu, mod, divu, div} = bits [3:0].
- req_src1  in  32  dividend (rj).
- req_src2  in  32  divisor (rk).
- flush  in  1  cancel in-flight or pending operation (exception/ertn).
- resp_valid  out  1  result held.
- resp_ready  in  1  consumer takes result.
- resp_result  out  32  quotient or remainder.
- busy  out  1  state != IDLE; used by EXE for stall.
- dividend_tdata, divisor_tdata  out  32 each  shared operand buses to both IPs, driven from latched operands.
- s_dividend_tvalid / s_divisor_tvalid  out  1 each  to signed IP.
- s_dividend_tready / s_divisor_tready  in  1 each.
- s_dout_tvalid  in  1; s_dout_tdata  in  64, {quotient[63:32], remainder[31:0]}.
- u_dividend_tvalid / u_divisor_tvalid  out  1 each.
- u_dividend_tready / u_divisor_tready  in  1 each.
- u_dout_tvalid  in  1; u_dout_tdata  in  64, same layout.

## Operation
- States: IDLE, SEND, WAIT, DONE, DRAIN.
- Latched registers: op (4), src1, src2, sel_signed = op.div | op.mod, sel_rem = op.mod | op.modu, sent_dvd, sent_dvs, cancel, result (32).
- IDLE: on req_valid & !flush, latch op, operands and sel bits, clear sent flags and cancel, go to SEND. With req_valid & flush, nothing is latched. req_op with zero or multiple bits set is unsupported and is not checked.
- SEND:
  - The selected IP's dividend tvalid = !sent_dvd; divisor tvalid = !sent_dvs. The unselected IP's tvalids stay 0.
  - Each channel completes independently on tvalid & tready and sets its sent flag.
  - When both are complete (same cycle or different cycles), go to WAIT, or to DRAIN if cancel is set.
- Flush in SEND:
  - Neither channel accepted yet, counting this cycle: go straight to IDLE.
  - Otherwise set cancel and keep sending the remaining channel.
- WAIT: on the selected dout_tvalid, capture result = sel_rem ? tdata[31:0] : tdata[63:32] and go to DONE. On flush without dout_tvalid, go to DRAIN. On flush and dout_tvalid in the same cycle, go to IDLE and discard.
- DONE: resp_valid = 1 and resp_result is stable. resp_ready returns to IDLE. flush returns to IDLE and drops the result; flush wins over resp_ready, so no handshake occurs.
- DRAIN: wait for the selected dout_tvalid, discard it, go to IDLE. flush is ignored here.
- The unselected IP's dout_tvalid is ignored in every state.
- Divide-by-zero and overflow results are whatever the IP produces, passed through unmodified.

## Timing
- Reset values: state IDLE, all tvalids 0, resp_valid 0, resp_result 0, busy 0, req_ready 1.
- Request accepted in cycle T; operand tvalids first high in T+1.
- With both treadys high at T+1, WAIT starts at T+2.
- dout_tvalid in cycle D gives resp_valid high from D+1.
- Total latency is IP latency + 2 cycles minimum.
- resp handshake in cycle R puts the block in IDLE at R+1; next request accepted no earlier than R+1, so there is one bubble between operations.
- tvalid, once raised on a channel, is held until tready (AXI rule). tdata is constant for the whole operation.
- resetn low at any time: the async return to the reset values above. Any IP output arriving after reset is not tracked; the IPs share resetn.

## Test plan
- Signed div: div -7 / 2, IP model latency 8, tready always 1 → s_ tvalids high for one cycle; resp_result 0xFFFFFFFD at cycle T+10. mod of the same operands → 0xFFFFFFFF. u_ tvalids stay 0.
- Unsigned path: divu 0xFFFFFFFE / 3 → 0x55555554; modu 10 / 3 → 1. Only u_ tvalids toggle.
- Staggered handshake: dividend tready delayed 3 cycles, divisor tready delayed 1 → each tvalid drops the cycle after its own tready; WAIT entered only after the later one; result still correct.
- Flush cases:
  - Flush in SEND with no channel accepted → IDLE next cycle; later dout not expected.
  - Flush after divisor accepted only → dividend still sent, then DRAIN; dout discarded; resp_valid never rises.
  - Flush in WAIT → DRAIN, then IDLE one cycle after dout_tvalid.
- Backpressure and DONE flush: resp_ready held 0 for 5 cycles → resp_valid/resp_result stable; next req_valid not accepted until the cycle after handshake. Separate run: flush in DONE → resp_valid low the next cycle.
- Reset mid-operation: resetn low during WAIT → all outputs at reset values immediately; after release, a new div 100 / 7 returns 14.

Source files
------------

// File: rtl/div_sequencer.sv
// div_sequencer: EXE-stage controller for div/divu/mod/modu.
// Drives one of two AXI-Stream divider IPs; drains cancelled ops.
module div_sequencer (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_src1,
  input  logic [31:0] req_src2,
  input  logic        flush,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_result,
  output logic        busy,
  output logic [31:0] dividend_tdata,
  output logic [31:0] divisor_tdata,
  output logic        s_dividend_tvalid,
  output logic        s_divisor_tvalid,
  input  logic        s_dividend_tready,
  input  logic        s_divisor_tready,
  input  logic        s_dout_tvalid,
  input  logic [63:0] s_dout_tdata,
  output logic        u_dividend_tvalid,
  output logic        u_divisor_tvalid,
  input  logic        u_dividend_tready,
  input  logic        u_divisor_tready,
  input  logic        u_dout_tvalid,
  input  logic [63:0] u_dout_tdata
);

  typedef enum logic [2:0] {
    IDLE, SEND, WAIT, DONE, DRAIN
  } state_t;

  state_t      state, state_n;
  logic [31:0] src1, src2, result;
  logic        sel_signed, sel_rem;
  logic        sent_dvd, sent_dvs, cancel;
  logic        sent_dvd_n, sent_dvs_n, cancel_n;
  logic        latch, capture;
  logic        dvd_v, dvs_v;
  logic        dvd_fire, dvs_fire;
  logic        dvd_done, dvs_done;
  logic        dvd_rdy, dvs_rdy;
  logic        dout_v;
  logic [63:0] dout_d;

  assign dvd_v = (state == SEND) && !sent_dvd;
  assign dvs_v = (state == SEND) && !sent_dvs;

  assign dvd_rdy = sel_signed ? s_dividend_tready
                              : u_dividend_tready;
  assign dvs_rdy = sel_signed ? s_divisor_tready
                              : u_divisor_tready;

  assign dvd_fire = dvd_v && dvd_rdy;
  assign dvs_fire = dvs_v && dvs_rdy;
  assign dvd_done = sent_dvd || dvd_fire;
  assign dvs_done = sent_dvs || dvs_fire;

  assign dout_v = sel_signed ? s_dout_tvalid : u_dout_tvalid;
  assign dout_d = sel_signed ? s_dout_tdata  : u_dout_tdata;

  assign s_dividend_tvalid = dvd_v && sel_signed;
  assign s_divisor_tvalid  = dvs_v && sel_signed;
  assign u_dividend_tvalid = dvd_v && !sel_signed;
  assign u_divisor_tvalid  = dvs_v && !sel_signed;

  assign dividend_tdata = src1;
  assign divisor_tdata  = src2;

  assign req_ready   = (state == IDLE);
  assign busy        = (state != IDLE);
  assign resp_valid  = (state == DONE);
  assign resp_result = result;

  // Next-state: once any operand is handed over, the op must drain.
  always_comb begin
    state_n    = state;
    sent_dvd_n = sent_dvd;
    sent_dvs_n = sent_dvs;
    cancel_n   = cancel;
    latch      = 1'b0;
    capture    = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_valid && !flush) begin
          latch      = 1'b1;
          sent_dvd_n = 1'b0;
          sent_dvs_n = 1'b0;
          cancel_n   = 1'b0;
          state_n    = SEND;
        end
      end
      SEND: begin
        sent_dvd_n = dvd_done;
        sent_dvs_n = dvs_done;
        cancel_n   = cancel || flush;
        if (dvd_done && dvs_done) begin
          state_n = (cancel || flush) ? DRAIN : WAIT;
        end else if (flush && !dvd_done
                     && !dvs_done) begin
          state_n = IDLE;
        end
      end
      WAIT: begin
        if (dout_v) begin
          if (flush) begin
            state_n = IDLE;
          end else begin
            capture = 1'b1;
            state_n = DONE;
          end
        end else if (flush) begin
          state_n = DRAIN;
        end
      end
      DONE: begin
        if (flush || resp_ready) begin
          state_n = IDLE;
        end
      end
      DRAIN: begin
        if (dout_v) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, handshake flags, latched operands and result.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      sent_dvd   <= 1'b0;
      sent_dvs   <= 1'b0;
      cancel     <= 1'b0;
      src1       <= '0;
      src2       <= '0;
      sel_signed <= 1'b0;
      sel_rem    <= 1'b0;
      result     <= '0;
    end else begin
      state    <= state_n;
      sent_dvd <= sent_dvd_n;
      sent_dvs <= sent_dvs_n;
      cancel   <= cancel_n;
      if (latch) begin
        src1       <= req_src1;
        src2       <= req_src2;
        sel_signed <= req_op[0] | req_op[2];
        sel_rem    <= req_op[2] | req_op[3];
      end
      if (capture) begin
        result <= sel_rem ? dout_d[31:0]
                          : dout_d[63:32];
      end
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer: vector table plus corner sequences,
// behavioural divider IPs and a response scoreboard.
module tb_div_sequencer;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_op = '0;
  logic [31:0] req_src1 = '0;
  logic [31:0] req_src2 = '0;
  logic        flush = 1'b0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_result;
  logic        busy;
  logic [31:0] dividend_tdata, divisor_tdata;
  logic        s_dividend_tvalid, s_divisor_tvalid;
  logic        s_dividend_tready, s_divisor_tready;
  logic        s_dout_tvalid;
  logic [63:0] s_dout_tdata;
  logic        u_dividend_tvalid, u_divisor_tvalid;
  logic        u_dividend_tready, u_divisor_tready;
  logic        u_dout_tvalid;
  logic [63:0] u_dout_tdata;

  always #5 clk = ~clk;

  div_sequencer dut (
    .clk               (clk),
    .resetn            (resetn),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_op            (req_op),
    .req_src1          (req_src1),
    .req_src2          (req_src2),
    .flush             (flush),
    .resp_valid        (resp_valid),
    .resp_ready        (resp_ready),
    .resp_result       (resp_result),
    .busy              (busy),
    .dividend_tdata    (dividend_tdata),
    .divisor_tdata     (divisor_tdata),
    .s_dividend_tvalid (s_dividend_tvalid),
    .s_divisor_tvalid  (s_divisor_tvalid),
    .s_dividend_tready (s_dividend_tready),
    .s_divisor_tready  (s_divisor_tready),
    .s_dout_tvalid     (s_dout_tvalid),
    .s_dout_tdata      (s_dout_tdata),
    .u_dividend_tvalid (u_dividend_tvalid),
    .u_divisor_tvalid  (u_divisor_tvalid),
    .u_dividend_tready (u_dividend_tready),
    .u_divisor_tready  (u_divisor_tready),
    .u_dout_tvalid     (u_dout_tvalid),
    .u_dout_tdata      (u_dout_tdata)
  );

  // ---- divider IP models: index 0 signed, 1 unsigned
  int          dvd_dly = 0;
  int          dvs_dly = 0;
  int          lat = 8;
  logic [1:0]  dvd_v, dvs_v, dvd_r, dvs_r;
  logic [1:0]  dout_v, spur;
  logic [63:0] dout_d [2];
  int          dvd_cnt [2];
  int          dvs_cnt [2];
  int          pend [2];
  logic        got_dvd [2];
  logic        got_dvs [2];
  logic [31:0] a_m [2];
  logic [31:0] b_m [2];

  assign dvd_v = {u_dividend_tvalid, s_dividend_tvalid};
  assign dvs_v = {u_divisor_tvalid, s_divisor_tvalid};

  always_comb begin
    dvd_r = '0;
    dvs_r = '0;
    for (int i = 0; i < 2; i++) begin
      dvd_r[i] = (dvd_cnt[i] >= dvd_dly);
      dvs_r[i] = (dvs_cnt[i] >= dvs_dly);
    end
  end

  assign s_dividend_tready = dvd_r[0];
  assign s_divisor_tready  = dvs_r[0];
  assign u_dividend_tready = dvd_r[1];
  assign u_divisor_tready  = dvs_r[1];
  assign s_dout_tvalid = dout_v[0] | spur[0];
  assign u_dout_tvalid = dout_v[1] | spur[1];
  assign s_dout_tdata  = dout_d[0];
  assign u_dout_tdata  = dout_d[1];

  logic               fa, fb;
  logic [31:0]        av, bv;
  logic signed [31:0] sa, sb, sq, sr;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dout_v <= '0;
      for (int i = 0; i < 2; i++) begin
        dvd_cnt[i] <= 0;
        dvs_cnt[i] <= 0;
        pend[i]    <= 0;
        got_dvd[i] <= 1'b0;
        got_dvs[i] <= 1'b0;
        a_m[i]     <= '0;
        b_m[i]     <= '0;
        dout_d[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        fa = dvd_v[i] & dvd_r[i];
        fb = dvs_v[i] & dvs_r[i];
        av = fa ? dividend_tdata : a_m[i];
        bv = fb ? divisor_tdata : b_m[i];
        dvd_cnt[i] <= (dvd_v[i] && !fa) ? dvd_cnt[i] + 1 : 0;
        dvs_cnt[i] <= (dvs_v[i] && !fb) ? dvs_cnt[i] + 1 : 0;
        dout_v[i] <= (pend[i] == 1);
        if (pend[i] > 0) pend[i] <= pend[i] - 1;
        if (fa) a_m[i] <= dividend_tdata;
        if (fb) b_m[i] <= divisor_tdata;
        if ((got_dvd[i] | fa) && (got_dvs[i] | fb)) begin
          got_dvd[i] <= 1'b0;
          got_dvs[i] <= 1'b0;
          pend[i]    <= lat - 1;
          sa = av;
          sb = bv;
          sq = sa / sb;
          sr = sa % sb;
          if (i == 0) dout_d[i] <= {sq, sr};
          else        dout_d[i] <= {av / bv, av % bv};
        end else begin
          got_dvd[i] <= got_dvd[i] | fa;
          got_dvs[i] <= got_dvs[i] | fb;
        end
      end
    end
  end

  // ---- scoreboard and counters
  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] exp_q [$];
  int          c_dvd [2];
  int          c_dvs [2];
  bit          resp_any = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)",
               nm, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [31:0] e;
    if (resetn) begin
      for (int i = 0; i < 2; i++) begin
        c_dvd[i] = c_dvd[i] + int'(dvd_v[i]);
        c_dvs[i] = c_dvs[i] + int'(dvs_v[i]);
      end
      if (resp_valid) resp_any = 1'b1;
      if (resp_valid && resp_ready && !flush) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL resp_unexpected: got %h, none expected",
                   resp_result);
        end else begin
          e = exp_q.pop_front();
          if (resp_result !== e) begin
            n_bad++;
            $display("FAIL resp_result: got %h expected %h",
                     resp_result, e);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_counts();
    for (int i = 0; i < 2; i++) begin
      c_dvd[i] = 0;
      c_dvs[i] = 0;
    end
  endtask

  task automatic issue(input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] e, input bit want);
    int n;
    req_op = op;
    req_src1 = a;
    req_src2 = b;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 50) begin
      step();
      n++;
    end
    chk("req_ready_at_issue", req_ready, 1);
    if (want) exp_q.push_back(e);
    step();
    req_valid = 1'b0;
  endtask

  task automatic wait_resp();
    int n;
    n = 0;
    while (!resp_valid && n < 200) begin
      step();
      n++;
    end
    chk("resp_valid_rise", resp_valid, 1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || exp_q.size() != 0) && n < 200) begin
      step();
      n++;
    end
    chk("idle_reached", busy, 0);
    chk("scoreboard_empty", exp_q.size(), 0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req_ready"}, req_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_resp_valid"}, resp_valid, 0);
    chk({tag, "_resp_result"}, resp_result, 0);
    chk({tag, "_tvalids"},
        {28'd0, s_dividend_tvalid, s_divisor_tvalid,
         u_dividend_tvalid, u_divisor_tvalid}, 0);
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          lt;
    int          dd;
    int          ds;
    logic [31:0] e;
  } vec_t;

  localparam logic [3:0] OP_DIV  = 4'b0001;
  localparam logic [3:0] OP_DIVU = 4'b0010;
  localparam logic [3:0] OP_MOD  = 4'b0100;
  localparam logic [3:0] OP_MODU = 4'b1000;

  vec_t vt [8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int sel, cyc, mx, n;
    vt[0] = '{OP_DIV,  32'hFFFFFFF9, 32'd2, 8, 0, 0, 32'hFFFFFFFD};
    vt[1] = '{OP_MOD,  32'hFFFFFFF9, 32'd2, 8, 0, 0, 32'hFFFFFFFF};
    vt[2] = '{OP_DIVU, 32'hFFFFFFFE, 32'd3, 8, 0, 0, 32'h55555554};
    vt[3] = '{OP_MODU, 32'd10, 32'd3, 8, 0, 0, 32'd1};
    vt[4] = '{OP_DIV,  32'd100, 32'd7, 4, 3, 1, 32'd14};
    vt[5] = '{OP_MODU, 32'd100, 32'd7, 3, 1, 3, 32'd2};
    vt[6] = '{OP_MOD,  32'd7, 32'hFFFFFFFE, 2, 0, 2, 32'd1};
    vt[7] = '{OP_DIVU, 32'hFFFFFFF9, 32'd2, 5, 2, 2, 32'h7FFFFFFC};
    spur = '0;
    clr_counts();

    repeat (2) @(posedge clk);
    #1;
    chk_reset("rst");
    resetn = 1'b1;
    step();

    // table-driven operations with resp_ready held high
    for (int k = 0; k < 8; k++) begin
      lat = vt[k].lt;
      dvd_dly = vt[k].dd;
      dvs_dly = vt[k].ds;
      sel = (vt[k].op[0] | vt[k].op[2]) ? 0 : 1;
      clr_counts();
      issue(vt[k].op, vt[k].a, vt[k].b, vt[k].e, 1'b1);
      cyc = 1;
      while (!resp_valid && cyc < 200) begin
        spur[1-sel] = (cyc == 3);
        step();
        cyc++;
      end
      spur = '0;
      mx = (vt[k].dd > vt[k].ds) ? vt[k].dd : vt[k].ds;
      chk("latency", cyc, 2 + mx + vt[k].lt);
      step();
      chk("idle_after_resp", busy, 0);
      chk("sel_dvd_cycles", c_dvd[sel], vt[k].dd + 1);
      chk("sel_dvs_cycles", c_dvs[sel], vt[k].ds + 1);
      chk("unsel_tvalid_cycles",
          c_dvd[1-sel] + c_dvs[1-sel], 0);
      chk("scoreboard_drained", exp_q.size(), 0);
    end

    // flush in SEND before any channel is accepted
    lat = 3; dvd_dly = 5; dvs_dly = 5;
    resp_any = 1'b0;
    issue(OP_DIV, 32'd100, 32'd7, 0, 1'b0);
    chk("fa_tvalid_before", s_dividend_tvalid, 1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fa_idle", busy, 0);
    chk("fa_tvalid_after", s_dividend_tvalid, 0);
    repeat (15) step();
    chk("fa_no_resp", resp_any, 0);

    // flush after only the divisor was accepted
    lat = 4; dvd_dly = 3; dvs_dly = 0;
    resp_any = 1'b0;
    issue(OP_DIV, 32'd100, 32'd7, 0, 1'b0);
    step();
    chk("fb_dvs_done", s_divisor_tvalid, 0);
    chk("fb_dvd_pending", s_dividend_tvalid, 1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fb_still_busy", busy, 1);
    chk("fb_dvd_held", s_dividend_tvalid, 1);
    wait_idle();
    repeat (4) step();
    chk("fb_no_resp", resp_any, 0);

    // flush in WAIT, then drain to IDLE after dout
    lat = 6; dvd_dly = 0; dvs_dly = 0;
    resp_any = 1'b0;
    issue(OP_DIVU, 32'd100, 32'd7, 0, 1'b0);
    step();
    chk("fc_wait_busy", busy, 1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    n = 0;
    while (!u_dout_tvalid && n < 20) begin
      chk("fc_drain_busy", busy, 1);
      step();
      n++;
    end
    chk("fc_dout_seen", u_dout_tvalid, 1);
    chk("fc_busy_at_dout", busy, 1);
    step();
    chk("fc_idle_after_dout", busy, 0);
    chk("fc_no_resp", resp_any, 0);

    // response backpressure and the one-cycle bubble
    lat = 3;
    resp_ready = 1'b0;
    issue(OP_DIVU, 32'd100, 32'd7, 32'd14, 1'b1);
    wait_resp();
    req_op = OP_MODU;
    req_src1 = 32'd100;
    req_src2 = 32'd7;
    req_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", resp_valid, 1);
      chk("bp_result", resp_result, 14);
      chk("bp_req_ready", req_ready, 0);
      step();
    end
    resp_ready = 1'b1;
    exp_q.push_back(32'd2);
    chk("bp_valid_at_hs", resp_valid, 1);
    step();
    chk("bubble_req_ready", req_ready, 1);
    chk("bubble_resp_valid", resp_valid, 0);
    step();
    req_valid = 1'b0;
    chk("next_accepted", busy, 1);
    wait_idle();

    // flush while the result is held in DONE
    resp_ready = 1'b0;
    issue(OP_DIV, 32'd100, 32'd7, 0, 1'b0);
    wait_resp();
    chk("fd_result", resp_result, 14);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fd_valid_dropped", resp_valid, 0);
    chk("fd_idle", busy, 0);
    resp_ready = 1'b1;

    // asynchronous reset during WAIT
    lat = 10;
    issue(OP_DIV, 32'd100, 32'd7, 0, 1'b0);
    step();
    chk("rs_wait_busy", busy, 1);
    resetn = 1'b0;
    #1;
    chk_reset("midrst");
    step();
    step();
    resetn = 1'b1;
    step();
    issue(OP_DIV, 32'd100, 32'd7, 32'd14, 1'b1);
    wait_resp();
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
